// File: rtl/key_evt_arb.sv
// Round-robin arbiter turning debounced key press pulses into a paced valid/ready event stream.
// Optional coalesced-press counter enabled by defining KEY_EVT_DROP_CNT_EN.
module key_evt_arb #(
  parameter int unsigned N_KEYS  = 4,
  parameter int unsigned IDW     = 2,
  parameter logic [19:0] HOLDOFF = 20'd49_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [N_KEYS-1:0] key_flag,
  output logic              evt_valid,
  output logic [IDW-1:0]    evt_id,
  input  logic              evt_ready,
  output logic [N_KEYS-1:0] pend,
  output logic              busy
`ifdef KEY_EVT_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StOffer, StHold} state_e;

  state_e            state_q, state_d;
  logic [N_KEYS-1:0] pend_q, pend_d;
  logic              evt_valid_q, evt_valid_d;
  logic [IDW-1:0]    evt_id_q, evt_id_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [19:0]       cnt_q, cnt_d;

  logic              accept;
  logic [N_KEYS-1:0] clr;
  logic [IDW-1:0]    sel_id;
  logic [IDW-1:0]    cand;
  logic              sel_found;

  assign accept = evt_valid_q & evt_ready;
  assign clr    = accept ? (N_KEYS'(1) << evt_id_q) : '0;
  // A new press in the acceptance cycle survives the clear.
  assign pend_d = (pend_q & ~clr) | key_flag;

  // Circular scan starting just after the last granted key.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_KEYS; k++) begin
      cand = IDW'((32'(last_grant_q) + k) % N_KEYS);
      if (!sel_found && pend_q[cand]) begin
        sel_id    = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          evt_id_d    = sel_id;
          evt_valid_d = 1'b1;
          state_d     = StOffer;
        end
      end
      StOffer: begin
        if (accept) begin
          evt_valid_d  = 1'b0;
          last_grant_d = evt_id_q;
          cnt_d        = '0;
          state_d      = StHold;
        end
      end
      StHold: begin
        if (cnt_q == HOLDOFF) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d     = StIdle;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      pend_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= IDW'(N_KEYS - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pend      = pend_q;
  assign busy      = (state_q != StIdle);

`ifdef KEY_EVT_DROP_CNT_EN
  logic [N_KEYS-1:0] coal;
  logic [8:0]        drop_sum;
  logic [7:0]        drop_q, drop_d;

  assign coal     = key_flag & pend_q & ~clr;
  assign drop_sum = 9'(drop_q) + 9'($countones(coal));
  assign drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_key_evt_arb.sv
// Self-checking bench for key_evt_arb: directed scenarios plus randomized traffic against a
// cycle-level reference model derived from the timing rules.
module tb_key_evt_arb;
  localparam int unsigned N    = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned HOLD = 3;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic [N-1:0]   key_flag;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;
  logic [N-1:0]   pend;
  logic           busy;
`ifdef KEY_EVT_DROP_CNT_EN
  logic [7:0]     drop_cnt;
`endif

  key_evt_arb #(
    .N_KEYS (N),
    .IDW    (IDW),
    .HOLDOFF(20'(HOLD))
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_flag (key_flag),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready),
    .pend     (pend),
    .busy     (busy)
`ifdef KEY_EVT_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: current-cycle view of pend bitmap, offered event and pacing.
  bit [N-1:0] m_pend;
  bit         m_valid;
  int         m_id;
  int         m_lg;
  int         m_idle_from;  // first cycle at which a new selection may happen
  int         m_drop;

  function automatic bit m_busy();
    return m_valid || (cyc < m_idle_from);
  endfunction

  // Drive one cycle of inputs, advance the model, return #1 after the edge.
  task automatic tick(input logic [N-1:0] f, input logic r, input logic rst);
    bit [N-1:0] n_pend, clr, coal;
    bit n_valid;
    int n_id, n_lg, n_idle, n_drop;
    key_flag  = f;
    evt_ready = r;
    sys_rst_n = rst;
    if (!rst) begin
      n_pend = '0; n_valid = 0; n_id = 0; n_lg = N - 1; n_idle = cyc + 1; n_drop = 0;
    end else begin
      clr = '0; n_valid = m_valid; n_id = m_id; n_lg = m_lg; n_idle = m_idle_from;
      if (m_valid && r) begin
        clr[m_id] = 1'b1;
        n_valid   = 0;
        n_lg      = m_id;
        n_idle    = cyc + 2 + HOLD;
      end else if (!m_valid && cyc >= m_idle_from && m_pend != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (m_pend[(m_lg + k) % N]) begin
            n_id    = (m_lg + k) % N;
            n_valid = 1;
            break;
          end
        end
      end
      coal   = f & m_pend & ~clr;
      n_drop = m_drop + $countones(coal);
      if (n_drop > 255) n_drop = 255;
      n_pend = (m_pend & ~clr) | f;
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    m_pend = n_pend; m_valid = n_valid; m_id = n_id; m_lg = n_lg;
    m_idle_from = n_idle; m_drop = n_drop;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || pend != '0) && n < 100) begin
      tick('0, 1'b1, 1'b1);
      n++;
    end
    checks++;
    if (busy || pend != '0) begin
      failures++;
      $display("FAIL drain_timeout: busy=%0b pend=%0h required busy=0 pend=0", busy, pend);
    end
  endtask

  task automatic test_reset();
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    checks += 4;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b want 0", evt_valid); end
    if (evt_id !== '0) begin failures++; $display("FAIL rst_id: got %0h want 0", evt_id); end
    if (pend !== '0) begin failures++; $display("FAIL rst_pend: got %0h want 0", pend); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b want 0", busy); end
`ifdef KEY_EVT_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
`endif
    tick('0, 1'b0, 1'b1);
  endtask

  task automatic test_single_press();
    tick(4'b0100, 1'b1, 1'b1);  // t
    checks += 2;
    if (pend !== 4'b0100) begin failures++; $display("FAIL sp_pend_t1: got %0h want 4", pend); end
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL sp_valid_t1: got %0b want 0", evt_valid); end
    tick('0, 1'b1, 1'b1);
    checks += 2;
    if (evt_valid !== 1'b1) begin failures++; $display("FAIL sp_valid_t2: got %0b want 1", evt_valid); end
    if (evt_id !== 2'd2) begin failures++; $display("FAIL sp_id_t2: got %0d want 2", evt_id); end
    tick('0, 1'b1, 1'b1);
    checks += 3;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL sp_valid_t3: got %0b want 0", evt_valid); end
    if (pend !== '0) begin failures++; $display("FAIL sp_pend_t3: got %0h want 0", pend); end
    if (busy !== 1'b1) begin failures++; $display("FAIL sp_busy_t3: got %0b want 1", busy); end
    for (int i = 0; i < 4; i++) tick('0, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL sp_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_backpressure();
    tick(4'b0010, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid=%0b id=%0d want valid=1 id=1", i, evt_valid, evt_id);
      end
      tick('0, 1'b0, 1'b1);
    end
    tick('0, 1'b1, 1'b1);
    checks++;
    if (evt_valid !== 1'b0 || pend !== '0) begin
      failures++;
      $display("FAIL bp_accept: got valid=%0b pend=%0h want valid=0 pend=0", evt_valid, pend);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int ids[$];
    int rise[$];
    logic prev;
    tick('0, 1'b1, 1'b0);
    tick(4'b1111, 1'b1, 1'b1);
    prev = evt_valid;
    for (int i = 0; i < 40; i++) begin
      tick('0, 1'b1, 1'b1);
      if (evt_valid && !prev) begin
        ids.push_back(int'(evt_id));
        rise.push_back(cyc);
      end
      prev = evt_valid;
    end
    checks++;
    if (ids.size() != 4) begin
      failures++;
      $display("FAIL rr_count: got %0d events want 4", ids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ids[i] != i) begin failures++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, ids[i], i); end
        if (i > 0) begin
          checks++;
          if (rise[i] - rise[i-1] != 6) begin
            failures++;
            $display("FAIL rr_gap[%0d]: got %0d want 6", i, rise[i] - rise[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_coalesce();
    int events = 0;
    tick('0, 1'b0, 1'b0);
    tick(4'b1000, 1'b0, 1'b1);
    tick(4'b1000, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (evt_valid && evt_id == 2'd3) events++;
      tick('0, 1'b1, 1'b1);
    end
    checks++;
    if (events != 1) begin failures++; $display("FAIL coal_events: got %0d want 1", events); end
`ifdef KEY_EVT_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin failures++; $display("FAIL coal_drop: got %0d want 1", drop_cnt); end
`endif
    drain();
    // Press key 3 again in its own acceptance cycle.
    tick(4'b1000, 1'b1, 1'b1);
    tick('0, 1'b1, 1'b1);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      failures++;
      $display("FAIL sw_offer: got valid=%0b id=%0d want valid=1 id=3", evt_valid, evt_id);
    end
    tick(4'b1000, 1'b1, 1'b1);
    checks++;
    if (evt_valid !== 1'b0 || pend !== 4'b1000) begin
      failures++;
      $display("FAIL sw_pend: got valid=%0b pend=%0h want valid=0 pend=8", evt_valid, pend);
    end
    for (int i = 0; i < 4; i++) begin
      tick('0, 1'b1, 1'b1);
      checks++;
      if (evt_valid !== 1'b0) begin failures++; $display("FAIL sw_hold[%0d]: got %0b want 0", i, evt_valid); end
    end
    tick('0, 1'b1, 1'b1);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      failures++;
      $display("FAIL sw_second: got valid=%0b id=%0d want valid=1 id=3", evt_valid, evt_id);
    end
`ifdef KEY_EVT_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin failures++; $display("FAIL sw_drop: got %0d want 1", drop_cnt); end
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    tick('0, 1'b0, 1'b0);
    tick(4'b1010, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1 || pend !== 4'b1010) begin
      failures++;
      $display("FAIL rm_offer: got valid=%0b id=%0d pend=%0h want 1 1 a", evt_valid, evt_id, pend);
    end
    tick('0, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b0 || pend !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rm_abort: got valid=%0b pend=%0h busy=%0b want 0 0 0", evt_valid, pend, busy);
    end
    tick(4'b1000, 1'b1, 1'b1);
    tick('0, 1'b1, 1'b1);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      failures++;
      $display("FAIL rm_next: got valid=%0b id=%0d want valid=1 id=3", evt_valid, evt_id);
    end
    tick('0, 1'b1, 1'b1);
    checks++;
    if (pend !== '0 || evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_accept: got valid=%0b pend=%0h want 0 0", evt_valid, pend);
    end
    drain();
  endtask

  task automatic test_random();
    logic [N-1:0] f;
    for (int i = 0; i < 3000; i++) begin
      f = '0;
      for (int b = 0; b < N; b++) f[b] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) f = '0;
      tick(f, 1'($urandom_range(0, 1)), ($urandom_range(0, 249) != 0));
      checks++;
      if (evt_valid !== m_valid || evt_id !== IDW'(m_id) || pend !== m_pend || busy !== m_busy()) begin
        failures++;
        $display("FAIL rnd[%0d]: got v=%0b id=%0d p=%0h b=%0b want v=%0b id=%0d p=%0h b=%0b",
                 i, evt_valid, evt_id, pend, busy, m_valid, m_id, m_pend, m_busy());
      end
`ifdef KEY_EVT_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 8'(m_drop)) begin
        failures++;
        $display("FAIL rnd_drop[%0d]: got %0d want %0d", i, drop_cnt, m_drop);
      end
`endif
    end
  endtask

  initial begin
    key_flag  = '0;
    evt_ready = 1'b0;
    sys_rst_n = 1'b0;
    test_reset();
    test_single_press();
    test_backpressure();
    test_round_robin();
    test_coalesce();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
